// File: rtl/bcd_adder_serial.sv
// Serial multi-digit BCD adder: one decimal digit per clock, start/busy/done
// handshake, decimal-adjust correction and sticky invalid-digit flag.

// Single-digit decimal adder with correction and invalid-digit detect.
module bcd_digit (
  input  logic [3:0] da,
  input  logic [3:0] db,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co,
  output logic       bad
);
  logic [4:0] raw;

  // raw binary sum, then +6 adjust whenever it leaves the decimal range
  always_comb begin
    raw = {1'b0, da} + {1'b0, db} + {4'b0, ci};
    co  = raw > 5'd9;
    d   = co ? raw[3:0] + 4'd6 : raw[3:0];
    bad = (da > 4'd9) || (db > 4'd9);
  end
endmodule

module bcd_adder_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_w, b_w, sum_w, sum_nx;
  logic [W+3:0]  sum_cat;
  logic          c_w, err_w;
  logic [IW-1:0] idx;
  logic [3:0]    dig;
  logic          dco, dbad;

  // Operands are shifted right each cycle, so the active digit is always [3:0].
  bcd_digit u_dig (
    .da  (a_w[3:0]),
    .db  (b_w[3:0]),
    .ci  (c_w),
    .d   (dig),
    .co  (dco),
    .bad (dbad)
  );

  // New digit enters at the top; after DIGITS shifts digit 0 sits at [3:0].
  always_comb begin
    sum_cat = {dig, sum_w};
    sum_nx  = sum_cat[W+3:4];
  end

  // Control FSM with working and result registers; outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_w   <= '0;
      b_w   <= '0;
      sum_w <= '0;
      c_w   <= 1'b0;
      err_w <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_w   <= a;
            b_w   <= b;
            c_w   <= cin;
            sum_w <= '0;
            err_w <= 1'b0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_w   <= a_w >> 4;
          b_w   <= b_w >> 4;
          c_w   <= dco;
          err_w <= err_w | dbad;
          sum_w <= sum_nx;
          idx   <= idx + IW'(1);
          if (idx == LAST) begin
            sum   <= sum_nx;
            cout  <= dco;
            err   <= err_w | dbad;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_adder_serial.sv
// Directed bench for bcd_adder_serial: a 4-digit and a 1-digit instance.
module tb_bcd_adder_serial;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, err;
  logic [15:0] sum;
  logic        start1, cin1;
  logic [3:0]  a1, b1;
  logic        busy1, done1, cout1, err1;
  logic [3:0]  sum1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  bcd_adder_serial #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  bcd_adder_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One operation on the 4-digit instance; operands are scrambled after the
  // start sample to show they were latched. Returns done latency, busy cycles
  // and number of done pulses over a 12-edge window.
  task automatic run4(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                      output int lat, output int bcyc, output int ndone);
    @(negedge clk);
    a = ai; b = bi; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    bcyc = busy ? 1 : 0; lat = -1; ndone = 0;
    @(negedge clk);
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (busy) bcyc++;
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
    end
  endtask

  initial begin
    int lat, bcyc, nd;
    rst_n = 1'b0; start = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;

    run4(16'h1234, 16'h5678, 1'b0, lat, bcyc, nd);
    chk("add1_sum", sum, 16'h6912);
    chk("add1_cout", cout, 0);
    chk("add1_err", err, 0);
    chk("add1_lat", lat, 4);
    chk("add1_busy", bcyc, 5);
    chk("add1_ndone", nd, 1);

    run4(16'h9999, 16'h0001, 1'b0, lat, bcyc, nd);
    chk("ripple_sum", sum, 16'h0000);
    chk("ripple_cout", cout, 1);
    chk("ripple_err", err, 0);

    run4(16'h9999, 16'h9999, 1'b1, lat, bcyc, nd);
    chk("max_sum", sum, 16'h9999);
    chk("max_cout", cout, 1);
    chk("max_err", err, 0);

    run4(16'h00A0, 16'h0000, 1'b0, lat, bcyc, nd);
    chk("inv_sum", sum, 16'h0100);
    chk("inv_cout", cout, 0);
    chk("inv_err", err, 1);

    run4(16'h0005, 16'h0003, 1'b0, lat, bcyc, nd);
    chk("clr_sum", sum, 16'h0008);
    chk("clr_err", err, 0);

    // start held high through RUN and DONE: one done, result from first sample
    @(negedge clk);
    a = 16'h0450; b = 16'h0550; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    @(negedge clk); a = 16'h1111; b = 16'h2222;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    @(negedge clk); start = 1'b0;
    chk("hold_ndone", nd, 1);
    chk("hold_sum", sum, 16'h1000);
    chk("hold_cout", cout, 0);
    repeat (3) @(posedge clk);

    // leave err=1 in the result registers, then reset in the middle of RUN
    run4(16'h0B00, 16'h0000, 1'b0, lat, bcyc, nd);
    chk("pre_err", err, 1);
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_err", err, 0);
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("arst_nodone", nd, 0);

    run4(16'h0042, 16'h0058, 1'b0, lat, bcyc, nd);
    chk("post_sum", sum, 16'h0100);
    chk("post_lat", lat, 4);

    // DIGITS=1 instance
    @(negedge clk);
    a1 = 4'h5; b1 = 4'h4; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    lat = -1;
    @(negedge clk); start1 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (done1 && lat < 0) lat = n;
    end
    chk("d1_sum", sum1, 4'h0);
    chk("d1_cout", cout1, 1);
    chk("d1_lat", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
